decoder_2_4: RTL and testbench

Registered 2-to-4 one-hot decoder. Turns a 2-bit select (s1 = MSB, s0 = LSB) into four discrete one-hot lines y3..y0. Used as a small address or select decoder in combinational-datapath test designs. Outputs are registered on one clock and have one cycle of latency.

---
 rtl/decoder_pkg.sv | 25 ++
 rtl/decoder_2_4_core.sv | 24 ++
 rtl/decoder_2_4.sv | 68 ++++++
 tb/tb_decoder_2_4.sv | 120 ++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared select encodings and one-hot helper for the 2-to-4 decoder family.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package decoder_pkg;

    localparam logic [1:0] SEL_Y0 = 2'b00;
    localparam logic [1:0] SEL_Y1 = 2'b01;
    localparam logic [1:0] SEL_Y2 = 2'b10;
    localparam logic [1:0] SEL_Y3 = 2'b11;

    // Bit n of the result is set when sel selects line yn.
    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        logic [3:0] v;
        v = 4'b0000;
        case (sel)
            SEL_Y0:  v = 4'b0001;
            SEL_Y1:  v = 4'b0010;
            SEL_Y2:  v = 4'b0100;
            SEL_Y3:  v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/decoder_2_4_core.sv
// Combinational 2-to-4 one-hot decode with enable; logical (active-high) polarity.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   en   - when 0 the decoded vector is all zero
//   sel  - 2-bit select, sel[1] = MSB
//   dec  - one-hot vector, dec[n] set for sel == n
module decoder_2_4_core
    import decoder_pkg::*;
(
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] dec
);

    always_comb begin
        dec = 4'b0000;
        if (en) begin
            dec = onehot4(sel);
        end
    end

endmodule

// File: rtl/decoder_2_4.sv
// Registered 2-to-4 one-hot decoder with selectable output polarity.
// Latency: 1 cycle from sampled inputs to y3..y0/valid; no comb path in->out.
// Backpressure: none; a new decode is accepted every cycle.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous reset, active-high; overrides en and select
//   en     - decode enable; 0 drives all y inactive and valid low
//   s1,s0  - select, s1 = MSB
//   y3..y0 - registered decoded lines (inverted when ACTIVE_LOW=1)
//   valid  - registered y lines reflect an enabled decode
module decoder_2_4
    import decoder_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0,
    // Integration-level tie-off value for en; no effect on this logic.
    parameter bit EN_DEFAULT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic s1,
    input  logic s0,
    output logic y3,
    output logic y2,
    output logic y1,
    output logic y0,
    output logic valid
);

    localparam logic [3:0] POL_MASK = {4{ACTIVE_LOW}};

    logic [3:0] dec;
    logic [3:0] y_d;
    logic [3:0] y_q;
    logic       valid_q;

    logic unused_en_default;
    assign unused_en_default = EN_DEFAULT;

    decoder_2_4_core u_core (
        .en  (en),
        .sel ({s1, s0}),
        .dec (dec)
    );

    // Polarity is folded in once, ahead of the register, so the outputs come
    // straight off flops. A disabled decode (dec == 0) maps to the inactive
    // level automatically.
    assign y_d = dec ^ POL_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= POL_MASK;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= en;
        end
    end

    assign y3    = y_q[3];
    assign y2    = y_q[2];
    assign y1    = y_q[1];
    assign y0    = y_q[0];
    assign valid = valid_q;

endmodule

// File: tb/tb_decoder_2_4.sv
module tb_decoder_2_4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic s1  = 1'b1;
    logic s0  = 1'b1;

    logic h3, h2, h1, h0, hv;   // ACTIVE_LOW = 0 instance
    logic l3, l2, l1, l0, lv;   // ACTIVE_LOW = 1 instance

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decoder_2_4 #(.ACTIVE_LOW(1'b0), .EN_DEFAULT(1'b1)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .s1(s1), .s0(s0),
        .y3(h3), .y2(h2), .y1(h1), .y0(h0), .valid(hv)
    );

    decoder_2_4 #(.ACTIVE_LOW(1'b1), .EN_DEFAULT(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .s1(s1), .s0(s0),
        .y3(l3), .y2(l2), .y1(l1), .y0(l0), .valid(lv)
    );

    // Reference model: snapshot the inputs at each rising edge and derive
    // what the outputs must be for the following cycle.
    logic       started = 1'b0;
    logic [3:0] exp_vec = 4'b0000;
    logic       exp_vld = 1'b0;

    always @(posedge clk) begin
        exp_vld = !rst && en;
        exp_vec = exp_vld ? (4'b0001 << {s1, s0}) : 4'b0000;
        started = 1'b1;
    end

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
        end
    endtask

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check4("model_hi_y", {h3, h2, h1, h0}, exp_vec);
            check1("model_hi_valid", hv, exp_vld);
            check4("model_lo_y", {l3, l2, l1, l0}, ~exp_vec);
            check1("model_lo_valid", lv, exp_vld);
            n_cmp++;
            if (hv ? !$onehot({h3, h2, h1, h0}) : ({h3, h2, h1, h0} != 4'b0000)) begin
                n_bad++;
                $display("FAIL invariant: y=%b valid=%b at %0t", {h3, h2, h1, h0}, hv, $time);
            end
        end
    end

    // Drive one cycle of inputs (called at a falling edge), then at the next
    // falling edge check against hand-computed literals.
    task automatic cyc(input string name, input logic r, input logic e,
                       input logic a, input logic b,
                       input logic [3:0] want_hi, input logic [3:0] want_lo,
                       input logic want_v);
        rst = r; en = e; s1 = a; s0 = b;
        @(negedge clk);
        check4({name, "_hi"}, {h3, h2, h1, h0}, want_hi);
        check4({name, "_lo"}, {l3, l2, l1, l0}, want_lo);
        check1({name, "_v"}, hv, want_v);
        check1({name, "_vlo"}, lv, want_v);
    endtask

    initial begin
        @(negedge clk);

        // Reset with select/enable active: reset wins.
        cyc("rst_a", 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0);
        cyc("rst_b", 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0);

        // Full sweep.
        cyc("sw00", 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b1110, 1'b1);
        cyc("sw01", 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b1101, 1'b1);
        cyc("sw10", 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 4'b1011, 1'b1);
        cyc("sw11", 1'b0, 1'b1, 1'b1, 1'b1, 4'b1000, 4'b0111, 1'b1);

        // Enable gating with select 10 held.
        cyc("en1a", 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 4'b1011, 1'b1);
        cyc("en0",  1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0);
        cyc("en1b", 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 4'b1011, 1'b1);

        // Mid-operation reset.
        cyc("mr_pre",  1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b1101, 1'b1);
        cyc("mr_rst",  1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0);
        cyc("mr_post", 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b1101, 1'b1);

        // Randomized run; the model compare covers every cycle.
        for (int i = 0; i < 1000; i++) begin
            rst = ($urandom_range(0, 9) == 0);
            en  = ($urandom_range(0, 3) != 0);
            s1  = $urandom_range(0, 1);
            s0  = $urandom_range(0, 1);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
